// File: rtl/con_pkg.sv
// rtl/con_pkg.sv - screen geometry, control codes and FSM state encodings for the console writer
// Purpose: shared constants for text_console_writer.
// Ports: none (package).
package con_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 25;
    localparam int SCREEN_BYTES = COLS * ROWS * 2;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] DEF_ATTR = 8'h07;

    typedef logic [2:0] state_t;

    // ST_BOOT is the reset state: it holds every output quiet for the first
    // cycle after release and then picks CLEAR or IDLE.
    localparam state_t ST_BOOT      = 3'd0;
    localparam state_t ST_IDLE      = 3'd1;
    localparam state_t ST_WR_CHAR   = 3'd2;
    localparam state_t ST_WR_ATTR   = 3'd3;
    localparam state_t ST_SCROLL_RD = 3'd4;
    localparam state_t ST_SCROLL_WR = 3'd5;
    localparam state_t ST_FILL      = 3'd6;
    localparam state_t ST_CLEAR     = 3'd7;

endpackage

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to 80x25 char/attr video RAM writer with cursor and scroll
// Purpose: accepts bytes (valid/ready), writes char (even) / attr (odd) pairs,
//   interprets CR/LF/BS/FF, wraps lines, scrolls and clears the screen.
// Ports:
//   clock_25, reset_n          clock, asynchronous active-low reset
//   in_valid/in_data/in_attr   byte source; in_ready accepts in IDLE only
//   mem_address/wdata/we       video RAM write (and scroll read) port
//   mem_rdata                  RAM read data, one cycle after mem_address
//   cursor                     row*COLS+col for the display overlay
//   busy                       scroll or clear in progress
module text_console_writer
    import con_pkg::*;
#(
    parameter int COLS           = con_pkg::COLS,
    parameter int ROWS           = con_pkg::ROWS,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_attr,
    output logic        in_ready,
    output logic [11:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] cursor,
    output logic        busy
);

    localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
    localparam logic [11:0] LAST_BYTE = 12'(2 * COLS * ROWS - 1);
    localparam logic [11:0] FILL_BASE = 12'(2 * COLS * (ROWS - 1));
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [10:0] cursor_q, cursor_d;
    logic [11:0] cnt_q, cnt_d;      // scroll source / fill / clear address
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        char_d      = char_q;
        attr_d      = attr_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        mem_we      = 1'b0;
        mem_address = 12'd0;
        mem_wdata   = 8'd0;

        case (state_q)
            ST_BOOT: begin
                cnt_d   = 12'd0;
                state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    char_d = in_data;
                    attr_d = in_attr;
                    case (in_data)
                        CH_CR: col_d = 7'd0;
                        CH_BS: if (col_q != 7'd0) col_d = col_q - 7'd1;
                        CH_LF: begin
                            if (row_q < LAST_ROW) begin
                                row_d = row_q + 5'd1;
                            end else begin
                                state_d = ST_SCROLL_RD;
                                cnt_d   = ROW_BYTES;
                            end
                        end
                        CH_FF: begin
                            state_d = ST_CLEAR;
                            cnt_d   = 12'd0;
                            row_d   = 5'd0;
                            col_d   = 7'd0;
                        end
                        default: state_d = ST_WR_CHAR;
                    endcase
                end
            end
            ST_WR_CHAR: begin
                mem_we      = 1'b1;
                mem_address = {cursor_q, 1'b0};
                mem_wdata   = char_q;
                state_d     = ST_WR_ATTR;
            end
            ST_WR_ATTR: begin
                mem_we      = 1'b1;
                mem_address = {cursor_q, 1'b1};
                mem_wdata   = attr_q;
                state_d     = ST_IDLE;
                if (col_q < LAST_COL) begin
                    col_d = col_q + 7'd1;
                end else begin
                    col_d = 7'd0;
                    if (row_q < LAST_ROW) begin
                        row_d = row_q + 5'd1;
                    end else begin
                        state_d = ST_SCROLL_RD;
                        cnt_d   = ROW_BYTES;
                    end
                end
            end
            ST_SCROLL_RD: begin
                busy        = 1'b1;
                mem_address = cnt_q;
                state_d     = ST_SCROLL_WR;
            end
            ST_SCROLL_WR: begin
                // mem_rdata now holds the byte addressed in SCROLL_RD; copy it one row up.
                busy        = 1'b1;
                mem_we      = 1'b1;
                mem_address = cnt_q - ROW_BYTES;
                mem_wdata   = mem_rdata;
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_FILL;
                    cnt_d   = FILL_BASE;
                end else begin
                    state_d = ST_SCROLL_RD;
                    cnt_d   = cnt_q + 12'd1;
                end
            end
            ST_FILL, ST_CLEAR: begin
                busy        = 1'b1;
                mem_we      = 1'b1;
                mem_address = cnt_q;
                if (cnt_q[0])
                    mem_wdata = (state_q == ST_FILL) ? attr_q : DEF_ATTR;
                else
                    mem_wdata = CH_SPACE;
                if (cnt_q == LAST_BYTE)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q + 12'd1;
            end
            default: state_d = ST_BOOT;
        endcase

        cursor_d = 11'(row_d * COLS) + {4'd0, col_d};
    end

    assign cursor = cursor_q;

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BOOT;
            row_q    <= 5'd0;
            col_q    <= 7'd0;
            cursor_q <= 11'd0;
            cnt_q    <= 12'd0;
            char_q   <= 8'd0;
            attr_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cursor_q <= cursor_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
            attr_q   <= attr_d;
        end
    end

endmodule
